// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, and sticky overflow/underflow flags. Selectable read
//   style: registered read (FWFT=0) or first-word-fall-through (FWFT=1).
//
// Ports
//   clk           sole clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   cs            chip select; gates wr_en, rd_en and err_clr
//   wr_en         write request
//   rd_en         read / pop request
//   err_clr       clears the sticky overflow/underflow flags
//   data_in       write data
//   data_out      read data (registered or fall-through)
//   data_valid    qualifies data_out
//   empty, full, almost_empty, almost_full   status flags from count
//   count         current occupancy, 0..FIFO_DEPTH
//   overflow      sticky: write attempted while full with no pop
//   underflow     sticky: read attempted while empty
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          err_clr,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          data_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_evt;
  logic                  udf_evt;
  logic                  clr_req;

  // Flags are pure decodes of the registered count.
  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop frees a slot in the same edge, so a full FIFO can still take
  // a write when a read is accepted alongside it.
  assign rd_acc  = cs & rd_en & ~empty;
  assign wr_acc  = cs & wr_en & (~full | rd_acc);
  assign ovf_evt = cs & wr_en & full & ~rd_acc;
  assign udf_evt = cs & rd_en & empty;
  assign clr_req = cs & err_clr;

  // Storage is not reset; reset only blocks a write in its own cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy. Power-of-two depth makes the pointer wrap
  // a natural overflow of the AW-bit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky errors: a fresh event wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_evt | (overflow  & ~clr_req);
      underflow <= udf_evt | (underflow & ~clr_req);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; forced to zero while empty so
      // the output is defined after reset.
      assign data_out   = empty ? '0 : mem[rd_ptr];
      assign data_valid = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dvalid_q;

      // Registered read: the head is captured on the popping edge and
      // held until the next accepted read. When full with a concurrent
      // write, wr_ptr equals rd_ptr, and the nonblocking read still sees
      // the old head.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dvalid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out   = dout_q;
      assign data_valid = dvalid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags
//   Directed bench for sync_fifo_flags. Two instances share one stimulus
//   bus: u_reg (FWFT=0) and u_fwft (FWFT=1), both with default sizing.
module tb_sync_fifo_flags;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [31:0] data_in = '0;

  logic [31:0] r_dout;
  logic        r_dv, r_empty, r_full, r_ae, r_af, r_ovf, r_udf;
  logic [3:0]  r_count;

  logic [31:0] f_dout;
  logic        f_dv, f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
  logic [3:0]  f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.FWFT(0)) u_reg (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_in(data_in), .data_out(r_dout),
    .data_valid(r_dv), .empty(r_empty), .full(r_full),
    .almost_empty(r_ae), .almost_full(r_af), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf)
  );

  sync_fifo_flags #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
    .err_clr(err_clr), .data_in(data_in), .data_out(f_dout),
    .data_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_empty(f_ae), .almost_full(f_af), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // Drive one cycle of inputs, then wait until just after the edge.
  task automatic applyStimulus(input logic c, input logic w, input logic r,
                               input logic e, input logic [31:0] d);
    cs      = c;
    wr_en   = w;
    rd_en   = r;
    err_clr = e;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_word;
  int          mc;

  initial begin
    $display("[TB] start");

    // Reset state
    doReset();
    checkOutput("rst_count", r_count, 0);
    checkOutput("rst_empty", r_empty, 1);
    checkOutput("rst_ae", r_ae, 1);
    checkOutput("rst_full", r_full, 0);
    checkOutput("rst_af", r_af, 0);
    checkOutput("rst_dv", r_dv, 0);
    checkOutput("rst_dout", r_dout, 0);
    checkOutput("rst_ovf", r_ovf, 0);
    checkOutput("rst_udf", r_udf, 0);
    checkOutput("rst_fwft_dv", f_dv, 0);

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'(i));
      checkOutput("fill_count", r_count, 32'(i));
      checkOutput("fill_af", r_af, (i >= 6) ? 1 : 0);
      checkOutput("fill_ae", r_ae, (i <= 2) ? 1 : 0);
      checkOutput("fill_full", r_full, (i == 8) ? 1 : 0);
    end

    // Ninth write overflows
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h99);
    checkOutput("ovf_set", r_ovf, 1);
    checkOutput("ovf_count", r_count, 8);
    checkOutput("ovf_udf", r_udf, 0);

    // Drain: each word with a single-cycle valid, then hold
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("drain_dout", r_dout, 32'(i));
      checkOutput("drain_dv", r_dv, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("drain_dv_low", r_dv, 0);
      checkOutput("drain_hold", r_dout, 32'(i));
    end
    checkOutput("drain_empty", r_empty, 1);

    // Ninth read underflows, data_out holds
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("udf_set", r_udf, 1);
    checkOutput("udf_hold", r_dout, 8);
    checkOutput("udf_dv", r_dv, 0);

    // Clear ignored without cs, honoured with cs
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("clr_nocs_ovf", r_ovf, 1);
    checkOutput("clr_nocs_udf", r_udf, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("clr_ovf", r_ovf, 0);
    checkOutput("clr_udf", r_udf, 0);

    // Full with simultaneous write 0xA and read
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'(i));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'hA);
    checkOutput("fullrw_dout", r_dout, 1);
    checkOutput("fullrw_count", r_count, 8);
    checkOutput("fullrw_full", r_full, 1);
    checkOutput("fullrw_ovf", r_ovf, 0);
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("fullrw_drain", r_dout, (i == 9) ? 32'hA : 32'(i));
    end
    checkOutput("fullrw_empty", r_empty, 1);

    // Empty with simultaneous write and read: write only, underflow flags
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h33);
    checkOutput("emptyrw_count", r_count, 1);
    checkOutput("emptyrw_dv", r_dv, 0);
    checkOutput("emptyrw_udf", r_udf, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    checkOutput("emptyrw_dout", r_dout, 32'h33);
    checkOutput("emptyrw_clr", r_udf, 0);

    // Rejected requests with cs low
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h77);
    checkOutput("nocs_count", r_count, 0);

    // Interleaved stream of 20 words across pointer wrap
    mc = 0;
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(i));
      q.push_back(32'h100 + 32'(i));
      mc++;
      checkOutput("wrap_wcount", r_count, 32'(mc));
      checkOutput("wrap_wae", r_ae, (mc <= 2) ? 1 : 0);
      if (mc >= 3) begin
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        exp_word = q.pop_front();
        mc--;
        checkOutput("wrap_rdata", r_dout, exp_word);
        checkOutput("wrap_rae", r_ae, (mc <= 2) ? 1 : 0);
      end
    end
    while (q.size() > 0) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      exp_word = q.pop_front();
      checkOutput("wrap_tail", r_dout, exp_word);
    end
    checkOutput("wrap_empty", r_empty, 1);

    // FWFT instance: word written into empty appears next cycle
    doReset();
    checkOutput("fwft_rst_empty", f_empty, 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h55);
    checkOutput("fwft_dout", f_dout, 32'h55);
    checkOutput("fwft_dv", f_dv, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fwft_pop_empty", f_empty, 1);
    checkOutput("fwft_pop_dv", f_dv, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h66);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h77);
    checkOutput("fwft_head", f_dout, 32'h66);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("fwft_next", f_dout, 32'h77);
    checkOutput("fwft_next_dv", f_dv, 1);

    // Mid-operation reset with a write pending
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h200 + 32'(i));
    checkOutput("mid_pre_count", r_count, 5);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h2FF);
    rst = 1'b0;
    checkOutput("mid_count", r_count, 0);
    checkOutput("mid_empty", r_empty, 1);
    checkOutput("mid_ovf", r_ovf, 0);
    checkOutput("mid_udf", r_udf, 0);
    checkOutput("mid_dout", r_dout, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("mid_udf_after", r_udf, 1);
    checkOutput("mid_dv_after", r_dv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the data word width in bits (>=1).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, the number of storage entries (power of two, >=2).
REQ-003 The block SHALL have parameter AF_LEVEL, default FIFO_DEPTH-2, the occupancy at or above which almost_full asserts.
REQ-004 The block SHALL have parameter AE_LEVEL, default 2, the occupancy at or below which almost_empty asserts.
REQ-005 The block SHALL have parameter FWFT, default 0, where 0 selects registered-read mode and 1 selects first-word-fall-through mode.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 The block SHALL have port clk, input, 1 bit, the sole clock; all state updates on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-009 The block SHALL have port cs, input, 1 bit, chip select; when low, wr_en, rd_en and err_clr are ignored.
REQ-010 The block SHALL have port wr_en, input, 1 bit, the write request.
REQ-011 The block SHALL have port rd_en, input, 1 bit, the read/pop request.
REQ-012 The block SHALL have port err_clr, input, 1 bit, which clears the sticky error flags.
REQ-013 The block SHALL have port data_in, input, DATA_WIDTH bits, the write data.
REQ-014 The block SHALL have port data_out, output, DATA_WIDTH bits, the read data.
REQ-015 The block SHALL have port data_valid, output, 1 bit, which qualifies data_out.
REQ-016 The block SHALL have ports empty, full, almost_empty and almost_full, each an output of 1 bit, the status flags.
REQ-017 The block SHALL have port count, output, $clog2(FIFO_DEPTH)+1 bits, the current occupancy (0..FIFO_DEPTH).
REQ-018 The block SHALL have ports overflow and underflow, each an output of 1 bit, sticky error flags.

Function
REQ-019 A write SHALL be accepted when cs & wr_en & (!full | rd_acc), storing data_in at the write pointer and advancing the pointer modulo FIFO_DEPTH.
REQ-020 A read SHALL be accepted (rd_acc) when cs & rd_en & !empty, advancing the read pointer modulo FIFO_DEPTH.
REQ-021 When full and both requests are present, both SHALL be accepted, leaving count unchanged and full still asserted.
REQ-022 When empty and both requests are present, the write SHALL be accepted, the read rejected, and count SHALL become 1.
REQ-023 count SHALL be registered: +1 on write-only accept, -1 on read-only accept, unchanged otherwise.
REQ-024 The status flags SHALL be combinational from count: empty = (count==0); full = (count==FIFO_DEPTH); almost_full = (count>=AF_LEVEL); almost_empty = (count<=AE_LEVEL).
REQ-025 Pointer wrap SHALL be seamless; no entry is lost or duplicated across the FIFO_DEPTH-1 to 0 transition.
REQ-026 In FWFT=0 mode, on an accepted read data_out SHALL load the head entry at that edge, and data_valid SHALL be high for exactly the following cycle.
REQ-027 In FWFT=0 mode, data_out SHALL hold its value when no read is accepted.
REQ-028 In FWFT=1 mode, data_out SHALL equal the head entry whenever !empty, data_valid SHALL equal !empty, and an accepted read SHALL pop the head.
REQ-029 In FWFT=1 mode, a word written into an empty FIFO SHALL appear on data_out, with data_valid high, in the cycle after the write edge.
REQ-030 overflow SHALL set on cs & wr_en & full & !rd_acc and SHALL remain set until cleared.
REQ-031 underflow SHALL set on cs & rd_en & empty and SHALL remain set until cleared.
REQ-032 cs & err_clr SHALL clear both error flags, except that an error event in the same cycle SHALL leave its flag set.
REQ-033 Rejected requests SHALL NOT alter memory, the pointers, count or data_out.

Reset
REQ-034 On rst=1 at a rising clk edge, the pointers, count, data_out, data_valid, overflow and underflow SHALL go to 0, giving empty=1, almost_empty=1, full=0 and almost_full=0.
REQ-035 rst SHALL dominate cs, wr_en, rd_en and err_clr in the same cycle.
REQ-036 Storage contents SHALL NOT be reset.
REQ-037 A reset mid-operation SHALL discard all stored data.

Verification
REQ-038 Defaults, FWFT=0: write 8 words 0x1..0x8 -> full=1, almost_full=1 from count=6, count=8; a 9th write -> overflow=1 and count stays 8.
REQ-039 Defaults, FWFT=0: read 8 words -> data_out 0x1..0x8 in order, each with a 1-cycle data_valid, empty=1 after the last; a 9th read -> underflow=1 and data_out holds 0x8.
REQ-040 Full FIFO with simultaneous write of 0xA and read -> data_out=0x1, count=8, overflow stays 0; a later drain ends with 0xA.
REQ-041 FWFT=1, empty FIFO: write 0x55 -> next cycle data_out=0x55 and data_valid=1; then read -> empty=1 and data_valid=0.
REQ-042 Write 20 words with reads interleaved so that count stays in 1..4 -> order preserved across pointer wrap, almost_empty toggles at count 2/3.
REQ-043 Reset at count=5 with wr_en=1 -> count=0, empty=1, error flags 0; the next read reports underflow.
